// File: rtl/fifo_tree_sched_pkg.sv
// fifo_tree_sched_pkg: shared definitions for the clause FIFO tree sequencer.
//   - default clause count / width
//   - controller state encoding
//   - clog2 helper used to size internal counters
package fifo_tree_sched_pkg;

  localparam int unsigned CC_DEFAULT = 20;
  localparam int unsigned CW_DEFAULT = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_WAIT_RD,
    S_HOLD,
    S_OVF_CLR
  } state_t;

  // Bits needed to hold values 0..v-1, never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_tree_sched_outreg.sv
// fifo_tree_sched_outreg: single-entry valid/ready output hold register.
//   clk, reset : clock, synchronous active-high reset
//   i_load     : capture i_data and raise o_valid
//   i_data     : clause read back from the tree
//   i_ready    : consumer ready; o_valid drops on handshake
//   o_data     : held clause (stable while o_valid && !i_ready)
//   o_valid    : clause valid
module fifo_tree_sched_outreg #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid
);

  logic [W-1:0] r_data;
  logic         r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_load) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/fifo_tree_sched.sv
// fifo_tree_sched: sequencing controller for the clause FIFO tree.
// Accepts one batch of candidate clauses, writes it into the tree with a
// single wren cycle, then drains the tree one clause at a time to a
// valid/ready consumer. Sole driver of the tree's wren / rden / cOF.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   batch_i/batch_mask_i  packed clause ids (slot n at [CW*n +: CW]) / valid
//   batch_req_i/_ack_o    batch offer / 1-cycle accept pulse
//   clause_o/_valid_o     drained clause, held until clause_ready_i
//   done_o                1-cycle pulse when the batch is fully drained
//   ovf_o                 sticky overflow, cleared on next batch_ack_o
//   ft_*_o                tree controls and write data
//   ft_empty_i/ft_of_i    tree status, ft_clause_i tree read data
//
// Optional macro FIFO_TREE_SCHED_STATS_EN adds wrapping statistics outputs
// stat_batches_o, stat_clauses_o, stat_ovf_o.
module fifo_tree_sched
  import fifo_tree_sched_pkg::*;
#(
  parameter int unsigned CLAUSE_COUNT  = CC_DEFAULT,
  parameter int unsigned CLAUSE_WIDTH  = CW_DEFAULT,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned RD_LAT        = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [CLAUSE_WIDTH*CLAUSE_COUNT-1:0] batch_i,
  input  logic [CLAUSE_COUNT-1:0]              batch_mask_i,
  input  logic                                 batch_req_i,
  output logic                                 batch_ack_o,
  output logic [CLAUSE_WIDTH-1:0]              clause_o,
  output logic                                 clause_valid_o,
  input  logic                                 clause_ready_i,
  output logic                                 done_o,
  output logic                                 ovf_o,
  output logic [CLAUSE_WIDTH*CLAUSE_COUNT-1:0] ft_clauses_o,
  output logic [CLAUSE_COUNT-1:0]              ft_valid_o,
  output logic                                 ft_wren_o,
  output logic                                 ft_rden_o,
  output logic                                 ft_cof_o,
  input  logic                                 ft_empty_i,
  input  logic                                 ft_of_i,
  input  logic [CLAUSE_WIDTH-1:0]              ft_clause_i
`ifdef FIFO_TREE_SCHED_STATS_EN
  ,
  output logic [15:0]                          stat_batches_o,
  output logic [15:0]                          stat_clauses_o,
  output logic [7:0]                           stat_ovf_o
`endif
);

  localparam int unsigned ECW = clog2(SETTLE_CYCLES + 1);
  localparam int unsigned RCW = clog2(RD_LAT + 1);

  state_t         r_state;
  state_t         w_state_next;
  logic [ECW-1:0] r_empty_cnt;
  logic [RCW-1:0] r_rd_cnt;
  logic           r_of_pend;
  logic           r_ovf;
  logic           w_of;
  logic           w_rd_done;
  logic           w_load_out;
  logic           w_hs;
  logic           w_settled;

  // Overflow raised outside DRAIN is remembered and serviced on DRAIN entry.
  assign w_of      = ft_of_i | r_of_pend;
  assign w_rd_done = (r_rd_cnt == RCW'(RD_LAT - 1));
  assign w_hs      = clause_valid_o & clause_ready_i;
  assign w_settled = (r_empty_cnt == ECW'(SETTLE_CYCLES));

  always_comb begin
    w_state_next = r_state;
    batch_ack_o  = 1'b0;
    ft_wren_o    = 1'b0;
    ft_rden_o    = 1'b0;
    ft_cof_o     = 1'b0;
    done_o       = 1'b0;
    w_load_out   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated by reset so an offer is never acknowledged during reset.
        batch_ack_o = batch_req_i & ~reset;
        if (batch_req_i) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        ft_wren_o    = 1'b1;
        w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_of) begin
          w_state_next = S_OVF_CLR;
        end else if (!ft_empty_i) begin
          ft_rden_o    = 1'b1;
          w_state_next = S_WAIT_RD;
        end else if (w_settled) begin
          done_o       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_WAIT_RD: begin
        if (w_rd_done) begin
          w_load_out   = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_hs) w_state_next = S_DRAIN;
      end
      S_OVF_CLR: begin
        ft_cof_o     = 1'b1;
        w_state_next = S_DRAIN;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_empty_cnt  <= '0;
      r_rd_cnt     <= '0;
      r_of_pend    <= 1'b0;
      r_ovf        <= 1'b0;
      ft_clauses_o <= '0;
      ft_valid_o   <= '0;
    end else begin
      r_state <= w_state_next;

      if (batch_ack_o) begin
        ft_clauses_o <= batch_i;
        ft_valid_o   <= batch_mask_i;
        r_ovf        <= 1'b0;
        r_empty_cnt  <= '0;
      end else if (r_state == S_OVF_CLR) begin
        r_ovf <= 1'b1;
      end

      if (ft_rden_o) begin
        r_empty_cnt <= '0;
      end else if (r_state == S_DRAIN && !w_of && ft_empty_i && !w_settled) begin
        r_empty_cnt <= r_empty_cnt + ECW'(1);
      end

      if (r_state == S_WAIT_RD) begin
        r_rd_cnt <= w_rd_done ? '0 : r_rd_cnt + RCW'(1);
      end

      // The tree still shows OF during OVF_CLR (cleared by that cOF edge),
      // so that cycle must not re-arm the pending flag.
      if (r_state == S_OVF_CLR) begin
        r_of_pend <= 1'b0;
      end else if (r_state != S_DRAIN && ft_of_i) begin
        r_of_pend <= 1'b1;
      end
    end
  end

  assign ovf_o = r_ovf;

  fifo_tree_sched_outreg #(
    .W (CLAUSE_WIDTH)
  ) u_outreg (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load_out),
    .i_data  (ft_clause_i),
    .i_ready (clause_ready_i),
    .o_data  (clause_o),
    .o_valid (clause_valid_o)
  );

`ifdef FIFO_TREE_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_batches_o <= '0;
      stat_clauses_o <= '0;
      stat_ovf_o     <= '0;
    end else begin
      if (batch_ack_o) stat_batches_o <= stat_batches_o + 16'd1;
      if (w_hs)        stat_clauses_o <= stat_clauses_o + 16'd1;
      if (ft_cof_o)    stat_ovf_o     <= stat_ovf_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_tree_sched.sv
module tb_fifo_tree_sched;

  localparam int unsigned CC     = 20;
  localparam int unsigned CW     = 9;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned RDL    = 1;

  logic             clk;
  logic             reset;
  logic [CW*CC-1:0] batch_i;
  logic [CC-1:0]    batch_mask_i;
  logic             batch_req_i;
  logic             batch_ack_o;
  logic [CW-1:0]    clause_o;
  logic             clause_valid_o;
  logic             clause_ready_i;
  logic             done_o;
  logic             ovf_o;
  logic [CW*CC-1:0] ft_clauses_o;
  logic [CC-1:0]    ft_valid_o;
  logic             ft_wren_o;
  logic             ft_rden_o;
  logic             ft_cof_o;
  logic             ft_empty_i;
  logic             ft_of_i;
  logic [CW-1:0]    ft_clause_i;

  fifo_tree_sched #(
    .CLAUSE_COUNT  (CC),
    .CLAUSE_WIDTH  (CW),
    .SETTLE_CYCLES (SETTLE),
    .RD_LAT        (RDL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .batch_i        (batch_i),
    .batch_mask_i   (batch_mask_i),
    .batch_req_i    (batch_req_i),
    .batch_ack_o    (batch_ack_o),
    .clause_o       (clause_o),
    .clause_valid_o (clause_valid_o),
    .clause_ready_i (clause_ready_i),
    .done_o         (done_o),
    .ovf_o          (ovf_o),
    .ft_clauses_o   (ft_clauses_o),
    .ft_valid_o     (ft_valid_o),
    .ft_wren_o      (ft_wren_o),
    .ft_rden_o      (ft_rden_o),
    .ft_cof_o       (ft_cof_o),
    .ft_empty_i     (ft_empty_i),
    .ft_of_i        (ft_of_i),
    .ft_clause_i    (ft_clause_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural tree: FIFO of written clauses, RD_LAT=1 read, OF until cOF.
  logic [CW-1:0] mq[$];
  int            m_cnt;
  logic          m_of;
  logic          of_inject;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_cnt       <= 0;
      m_of        <= 1'b0;
      ft_clause_i <= '0;
    end else begin
      if (ft_wren_o)
        for (int i = 0; i < CC; i++)
          if (ft_valid_o[i]) mq.push_back(ft_clauses_o[CW*i +: CW]);
      if (ft_rden_o && mq.size() > 0) ft_clause_i <= mq.pop_front();
      m_cnt <= mq.size();
      if (ft_cof_o) m_of <= 1'b0;
      else if (of_inject) m_of <= 1'b1;
    end
  end

  assign ft_empty_i = (m_cnt == 0);
  assign ft_of_i    = m_of;

  // Scoreboard and event monitor, sampled mid-cycle.
  logic [CW-1:0] sb[$];
  int unsigned   cyc = 0;
  int unsigned   n_hs = 0, n_done = 0, n_wren = 0, n_rden = 0, n_cof = 0, n_valid = 0;
  int unsigned   last_done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (clause_valid_o && clause_ready_i) begin
        n_hs++;
        if (sb.size() == 0) check_eq("hs_no_expect", {23'd0, clause_o}, 32'hFFFF_FFFF);
        else                check_eq("hs_clause", {23'd0, clause_o}, {23'd0, sb.pop_front()});
      end
      if (done_o) begin
        n_done++;
        last_done_cyc = cyc;
      end
      if (ft_wren_o)      n_wren++;
      if (ft_rden_o)      n_rden++;
      if (ft_cof_o)       n_cof++;
      if (clause_valid_o) n_valid++;
    end
  end

  task automatic send_batch(input logic [CW*CC-1:0] b, input logic [CC-1:0] m,
                            output int unsigned ack_cyc);
    bit accepted;
    accepted       = 1'b0;
    ack_cyc        = 0;
    batch_i        = b;
    batch_mask_i   = m;
    batch_req_i    = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (batch_ack_o) begin
        accepted = 1'b1;
        ack_cyc  = cyc;
        for (int i = 0; i < CC; i++)
          if (m[i]) sb.push_back(b[CW*i +: CW]);
        break;
      end
    end
    check_eq("batch_ack", {31'd0, accepted}, 32'd1);
    @(posedge clk); #1;
    batch_req_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq(tag, {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic [CW*CC-1:0] mk2(input logic [CW-1:0] a, input int unsigned sa,
                                           input logic [CW-1:0] c, input int unsigned sc);
    logic [CW*CC-1:0] v;
    v = '0;
    v[CW*sa +: CW] = a;
    v[CW*sc +: CW] = c;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ack_c, ack2_c, rel_c, d0, h0, w0, v0, c0, r0, unstable;
    bit          seen;
    reset          = 1'b1;
    batch_i        = '0;
    batch_mask_i   = '0;
    batch_req_i    = 1'b0;
    clause_ready_i = 1'b1;
    of_inject      = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_ack",   {31'd0, batch_ack_o},    32'd0);
    check_eq("rst_valid", {31'd0, clause_valid_o}, 32'd0);
    check_eq("rst_done",  {31'd0, done_o},         32'd0);
    check_eq("rst_ovf",   {31'd0, ovf_o},          32'd0);
    check_eq("rst_wren",  {31'd0, ft_wren_o},      32'd0);
    check_eq("rst_rden",  {31'd0, ft_rden_o},      32'd0);
    check_eq("rst_cof",   {31'd0, ft_cof_o},       32'd0);
    check_eq("rst_ftval", {12'd0, ft_valid_o},     32'd0);
    check_eq("rst_clause",{23'd0, clause_o},       32'd0);
    @(posedge clk); #1;

    // Two clauses, ready high
    d0 = n_done; h0 = n_hs;
    send_batch(mk2(9'h011, 0, 9'h022, 2), 20'h00005, ack_c);
    wait_done("t1_done");
    check_eq("t1_hs",    n_hs - h0,   32'd2);
    check_eq("t1_ndone", n_done - d0, 32'd1);
    check_eq("t1_ovf",   {31'd0, ovf_o}, 32'd0);
    check_eq("t1_sb",    sb.size(),   32'd0);

    // Same batch, consumer stalls 10 cycles on the first clause
    clause_ready_i = 1'b0;
    h0 = n_hs;
    send_batch(mk2(9'h011, 0, 9'h022, 2), 20'h00005, ack_c);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (clause_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("t2_valid", {31'd0, seen}, 32'd1);
    r0 = n_rden; unstable = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      if (!(clause_valid_o && clause_o == 9'h011)) unstable++;
    end
    check_eq("t2_stable",  unstable,      32'd0);
    check_eq("t2_no_rden", n_rden - r0,   32'd0);
    @(posedge clk); #1;
    clause_ready_i = 1'b1;
    wait_done("t2_done");
    check_eq("t2_hs", n_hs - h0, 32'd2);

    // Empty batch: minimum turnaround
    w0 = n_wren; v0 = n_valid;
    send_batch('0, '0, ack_c);
    wait_done("t3_done");
    check_eq("t3_turnaround", last_done_cyc - ack_c, 2 + SETTLE);
    check_eq("t3_wren",       n_wren - w0,           32'd1);
    check_eq("t3_novalid",    n_valid - v0,          32'd0);

    // Overflow raised by the tree while draining
    c0 = n_cof;
    send_batch('0, '0, ack_c);
    of_inject = 1'b1;
    @(posedge clk); #1;
    of_inject = 1'b0;
    wait_done("t4_done");
    check_eq("t4_cof_pulse", n_cof - c0,      32'd1);
    check_eq("t4_ovf_set",   {31'd0, ovf_o},  32'd1);
    repeat (5) @(posedge clk); #1;
    check_eq("t4_ovf_sticky", {31'd0, ovf_o}, 32'd1);
    send_batch('0, '0, ack_c);
    check_eq("t4_ovf_clear",  {31'd0, ovf_o}, 32'd0);
    wait_done("t4b_done");

    // Reset asserted while a clause is held
    clause_ready_i = 1'b0;
    send_batch(mk2(9'h0AA, 1, 9'h0BB, 5), 20'h00022, ack_c);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (clause_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("t5_valid", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    reset        = 1'b1;
    batch_req_i  = 1'b1;
    sb.delete();
    @(negedge clk);
    check_eq("t5_ack_in_rst", {31'd0, batch_ack_o}, 32'd0);
    @(posedge clk); #1;
    check_eq("t5_valid_drop", {31'd0, clause_valid_o}, 32'd0);
    reset          = 1'b0;
    clause_ready_i = 1'b1;
    rel_c          = cyc;
    send_batch(mk2(9'h033, 0, 9'h044, 3), 20'h00009, ack_c);
    check_eq("t5_ack_follows", ack_c - rel_c, 32'd0);
    wait_done("t5_done");

    // Back-to-back batches with request held high
    h0 = n_hs;
    send_batch(mk2(9'h055, 0, 9'h066, 1), 20'h00003, ack_c);
    d0 = n_done;
    batch_req_i  = 1'b1;
    batch_i      = mk2(9'h077, 4, 9'h088, 7);
    batch_mask_i = 20'h00090;
    seen = 1'b0; ack2_c = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (batch_ack_o) begin
        seen   = 1'b1;
        ack2_c = cyc;
        sb.push_back(9'h077);
        sb.push_back(9'h088);
        break;
      end
    end
    check_eq("t6_ack2", {31'd0, seen}, 32'd1);
    check_eq("t6_done_before", n_done - d0, 32'd1);
    check_eq("t6_ack_after_done", ack2_c - last_done_cyc, 32'd1);
    @(posedge clk); #1;
    batch_req_i = 1'b0;
    wait_done("t6_done");
    check_eq("t6_hs", n_hs - h0, 32'd4);
    check_eq("t6_sb", sb.size(), 32'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
